// File: rtl/ysyx_041461_icache_ctrl_if.sv
// ---------------------------------------------------------------------------
// ysyx_041461_icache_ctrl_if
//   Bundle of every signal of the IF1 instruction-cache controller except
//   clk/rst: fetch request, result to IF2, control (fence_i / flush), the
//   shared port of the four 128-bit instruction SRAMs, and the single-beat
//   AXI read channel.
//
//   Parameter: IDX_W - set index width (sram_addr width).
//
//   Modports:
//     master - the cache controller (drives req_ready, out_*, hit_way,
//              trap_out, sram_*, axi_arvalid/araddr/rready, axi_rdata_q)
//     slave  - the surrounding fetch pipeline, SRAM macros and AXI port
//
//   Handshakes (req, out, axi ar, axi r): a transfer happens on the rising
//   clk edge where valid and ready are both high. Once raised, valid is held
//   with stable payload until that edge; the only exception is out_valid,
//   which is withdrawn in the same cycle that flush is asserted because the
//   result is being discarded.
// ---------------------------------------------------------------------------
interface ysyx_041461_icache_ctrl_if #(parameter int IDX_W = 4);
  logic              req_valid;
  logic [63:0]       req_pc;
  logic              req_ready;
  logic              fence_i;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_pc;
  logic [7:0]        hit_way;
  logic [3:0]        trap_out;
  logic [3:0]        sram_cen;
  logic [3:0]        sram_wen;
  logic [IDX_W-1:0]  sram_addr;
  logic [127:0]      sram_bwen;
  logic [127:0]      sram_wdata;
  logic              axi_arvalid;
  logic              axi_arready;
  logic [63:0]       axi_araddr;
  logic              axi_rvalid;
  logic              axi_rready;
  logic [1:0]        axi_rresp;
  logic [63:0]       axi_rdata;
  logic [63:0]       axi_rdata_q;

  modport master (
    input  req_valid, req_pc, fence_i, flush, out_ready,
    input  axi_arready, axi_rvalid, axi_rresp, axi_rdata,
    output req_ready, out_valid, out_pc, hit_way, trap_out,
    output sram_cen, sram_wen, sram_addr, sram_bwen, sram_wdata,
    output axi_arvalid, axi_araddr, axi_rready, axi_rdata_q
  );

  modport slave (
    output req_valid, req_pc, fence_i, flush, out_ready,
    output axi_arready, axi_rvalid, axi_rresp, axi_rdata,
    input  req_ready, out_valid, out_pc, hit_way, trap_out,
    input  sram_cen, sram_wen, sram_addr, sram_bwen, sram_wdata,
    input  axi_arvalid, axi_araddr, axi_rready, axi_rdata_q
  );
endinterface

// File: rtl/ysyx_041461_icache_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_041461_icache_ctrl
//   IF1 instruction-cache controller. Owns the 8-way tag/valid flop arrays,
//   drives the four 128-bit instruction SRAMs (two 64-bit ways per row),
//   produces the one-hot hit vector for IF2, runs a single-beat AXI read on
//   a miss, refills the victim way and forwards the registered AXI beat.
//
//   Ports:
//     clk, rst   - clock; asynchronous active-high reset
//     bus        - ysyx_041461_icache_ctrl_if.master (request, result,
//                  fence_i/flush, SRAM port, AXI read channel)
//     dbg_state  - current FSM state (state_t encoding)
//
//   Build option: define YSYX_041461_ICACHE_EN to build the cache. Without
//   it every fetch goes to AXI, hit_way stays 0, the SRAMs are never enabled
//   and no tag/valid storage exists; fence_i still takes its single cycle.
// ---------------------------------------------------------------------------
module ysyx_041461_icache_ctrl #(
  parameter int IDX_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_041461_icache_ctrl_if.master   bus,
  output logic [2:0]                  dbg_state
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_AR, S_R, S_FILL, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q;
  logic [7:0]  hit_way_q;
  logic        trap_q;
  logic [63:0] rdata_q;
  logic        kill_q;
  logic        fence_pend_q;

  logic [7:0]  hit_vec;        // lookup result for bus.req_pc
  logic        fill_cacheable; // latched pc may be allocated
  logic        accept;
  logic        fence_now;      // valid-bit clear happens this cycle
  logic        kill_eff;

  // ---------------- next state / handshake outputs ----------------
  always_comb begin
    state_d         = state_q;
    bus.req_ready   = 1'b0;
    bus.out_valid   = 1'b0;
    bus.axi_arvalid = 1'b0;
    bus.axi_rready  = 1'b0;
    fence_now       = 1'b0;
    kill_eff        = kill_q | bus.flush;
    case (state_q)
      S_IDLE: begin
        fence_now     = bus.fence_i | fence_pend_q;
        bus.req_ready = !bus.flush && !fence_now;
      end
      S_LOOKUP: begin
        bus.out_valid = !bus.flush;
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (bus.out_ready) begin
          state_d = S_IDLE;
          // A fence seen now (or pended) must clear the arrays before the
          // next lookup, so the overlapping accept is suppressed.
          bus.req_ready = !bus.fence_i && !fence_pend_q;
        end
      end
      S_AR: begin
        bus.axi_arvalid = 1'b1;
        if (bus.axi_arready) state_d = S_R;
      end
      S_R: begin
        bus.axi_rready = 1'b1;
        if (bus.axi_rvalid) begin
          if (bus.axi_rresp != 2'b00 || !fill_cacheable)
            state_d = kill_eff ? S_IDLE : S_RESP;
          else
            state_d = S_FILL;
        end
      end
      S_FILL: state_d = kill_eff ? S_IDLE : S_RESP;
      S_RESP: begin
        bus.out_valid = !bus.flush;
        if (bus.flush || bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    accept = bus.req_valid && bus.req_ready;
    if (accept) state_d = (|hit_vec) ? S_LOOKUP : S_AR;
  end

  // ---------------- control registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= 64'h0;
      hit_way_q    <= 8'h0;
      trap_q       <= 1'b0;
      rdata_q      <= 64'h0;
      kill_q       <= 1'b0;
      fence_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q      <= bus.req_pc;
        hit_way_q <= hit_vec;
        trap_q    <= 1'b0;
      end
      if (state_q == S_R && bus.axi_rvalid) begin
        rdata_q <= bus.axi_rdata;
        trap_q  <= (bus.axi_rresp != 2'b00);
      end
      // The AXI beat is always collected; kill only suppresses the result.
      if (state_d == S_IDLE)
        kill_q <= 1'b0;
      else if (bus.flush && (state_q == S_AR || state_q == S_R || state_q == S_FILL))
        kill_q <= 1'b1;
      if (bus.fence_i && state_q != S_IDLE)
        fence_pend_q <= 1'b1;
      else if (fence_now)
        fence_pend_q <= 1'b0;
    end
  end

  assign bus.out_pc      = pc_q;
  assign bus.hit_way     = (state_q == S_LOOKUP) ? hit_way_q : 8'h0;
  assign bus.trap_out    = (state_q == S_RESP) ? {3'b000, trap_q} : 4'h0;
  assign bus.axi_araddr  = {pc_q[63:3], 3'b000};
  assign bus.axi_rdata_q = rdata_q;
  assign dbg_state       = state_q;

`ifdef YSYX_041461_ICACHE_EN
  localparam int SETS  = 1 << IDX_W;
  localparam int TAG_W = 32 - IDX_W - 3;

  logic [TAG_W-1:0] tag_q [8][SETS];
  logic [SETS-1:0]  valid_q [8];
  logic [2:0]       rr_q;
  logic [2:0]       victim;
  logic             do_fill;
  logic [IDX_W-1:0] req_idx, pc_idx;
  logic [TAG_W-1:0] req_tag, pc_tag;

  assign req_idx        = bus.req_pc[IDX_W+2:3];
  assign req_tag        = bus.req_pc[31:IDX_W+3];
  assign pc_idx         = pc_q[IDX_W+2:3];
  assign pc_tag         = pc_q[31:IDX_W+3];
  assign fill_cacheable = pc_q[31];
  assign do_fill        = (state_q == S_FILL);

  // pc[31]==0 is the uncacheable region: never hits, never allocates.
  always_comb begin
    hit_vec = 8'h0;
    for (int w = 0; w < 8; w++)
      hit_vec[w] = bus.req_pc[31] && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag);
  end

  // Lowest invalid way wins; a full set falls back to round-robin.
  always_comb begin
    victim = rr_q;
    for (int w = 7; w >= 0; w--)
      if (!valid_q[w][pc_idx]) victim = 3'(w);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < 8; w++) valid_q[w] <= '0;
      rr_q <= 3'd0;
    end else if (fence_now) begin
      for (int w = 0; w < 8; w++) valid_q[w] <= '0;
    end else if (do_fill) begin
      valid_q[victim][pc_idx] <= 1'b1;
      rr_q                    <= rr_q + 3'd1;
    end
  end

  // Tags are qualified by valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    if (do_fill) tag_q[victim][pc_idx] <= pc_tag;
  end

  always_comb begin
    bus.sram_cen   = 4'hF;
    bus.sram_wen   = 4'hF;
    bus.sram_addr  = '0;
    bus.sram_bwen  = {128{1'b1}};
    bus.sram_wdata = {rdata_q, rdata_q};
    if (accept) begin
      bus.sram_cen  = 4'h0;
      bus.sram_addr = req_idx;
    end else if (do_fill) begin
      bus.sram_cen[victim[2:1]] = 1'b0;
      bus.sram_wen[victim[2:1]] = 1'b0;
      bus.sram_addr             = pc_idx;
      bus.sram_bwen             = victim[0] ? {64'h0, {64{1'b1}}} : {{64{1'b1}}, 64'h0};
    end
  end
`else
  assign hit_vec        = 8'h0;
  assign fill_cacheable = 1'b0;
  assign bus.sram_cen   = 4'hF;
  assign bus.sram_wen   = 4'hF;
  assign bus.sram_addr  = '0;
  assign bus.sram_bwen  = {128{1'b1}};
  assign bus.sram_wdata = {rdata_q, rdata_q};
`endif
endmodule

// File: doc/ysyx_041461_icache_ctrl.md
# ysyx_041461_icache_ctrl

Instruction-cache controller for the fetch front end. It sits in IF1, ahead of the IF2 instruction-select stage, and owns the tag/valid arrays and the four 128-bit instruction SRAMs (two 64-bit ways per SRAM row, 8 ways in total). It performs the tag lookup and drives the one-hot way-hit vector to IF2. On a miss it runs a single-beat AXI read, refills the victim way and forwards the AXI data. It also handles fence.i invalidation and pipeline flushes.

## Interface
- IDX_W, 4, set index width; 2^IDX_W sets, line = 8 bytes, index = pc[IDX_W+2:3], tag = pc[31:IDX_W+3]
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  fetch request from PC stage
- req_pc  in  64  fetch address (4-byte aligned)
- req_ready  out  1  request accepted when req_valid && req_ready
- fence_i  in  1  invalidate all valid bits
- flush  in  1  kill in-flight fetch (redirect or trap)
- out_valid  out  1  result to IF2
- out_ready  in  1  IF2/ID ready
- out_pc  out  64  pc of the result
- hit_way  out  8  one-hot hit; bit n drives IF2 hit(n+1); all-zero means use axi_rdata
- trap_out  out  4  0 = none, 1 = instruction access fault (rresp != 0)
- sram_cen  out  4  per-SRAM chip enable, active-low
- sram_wen  out  4  per-SRAM write enable, active-low
- sram_addr  out  IDX_W  shared row address
- sram_bwen  out  128  shared bit write mask, active-low
- sram_wdata  out  128  shared write data
- axi_arvalid / axi_arready  out / in  1  AR handshake
- axi_araddr  out  64  {req_pc[63:3],3'b0}; arlen = 0, arsize = 3 (tied)
- axi_rvalid / axi_rready  in / out  1  R handshake
- axi_rresp  in  2  read response
- axi_rdata_q  out  64  registered AXI beat, wired to IF2 AXI data input

## Operation
- States:
  - IDLE: req_ready=1.
  - LOOKUP: result held.
  - AR, R, FILL.
  - RESP: miss result held.
- IDLE, request accepted:
  - The controller latches pc.
  - It compares the tag against all 8 ways (flop arrays) combinationally.
  - It reads the indexed row from all four SRAMs (cen=4'b0000, wen=4'b1111).
  - Hit → LOOKUP. Miss → AR.
- LOOKUP:
  - out_valid=1 and hit_way is registered.
  - SRAMs are not re-enabled; IF2 holds the data itself.
  - On out_ready → IDLE, accepting a new request in the same cycle (req_ready = out_ready in LOOKUP).
- AR: arvalid=1 until arready, then → R.
- R:
  - rready=1. On rvalid the controller latches rdata into axi_rdata_q.
  - rresp != 0 → trap_out=1 and no fill, → RESP.
  - Otherwise → FILL.
- FILL (1 cycle):
  - Write the victim way: sram_cen[v>>1]=0, sram_wen[v>>1]=0.
  - v[0]=0 writes bits 63:0; v[0]=1 writes bits 127:64 (bwen low only on that half). wdata = {rdata, rdata}.
  - Set tag[v][idx] and valid[v][idx].
  - → RESP.
- RESP: out_valid=1, hit_way=0 (IF2 selects axi_rdata_q). On out_ready → IDLE.
- Victim selection: the lowest-numbered invalid way in the set; if all 8 are valid, the global 3-bit round-robin counter. The counter increments on every FILL.
- Uncacheable: pc[31]==0 is forced to miss and skips FILL (R → RESP).
- flush:
  - In LOOKUP or RESP: drop the result, out_valid=0, → IDLE.
  - In AR or R: set a kill flag. The AXI transaction completes, FILL is still performed if legal, then → IDLE with no out_valid.
  - In IDLE: blocks acceptance in that cycle.
- fence_i:
  - Clears all valid bits in one cycle. It is accepted only in IDLE; req_ready=0 that cycle.
  - Outside IDLE it is pended and applied on the next IDLE entry.

## Timing
- Reset:
  - State is IDLE.
  - Outputs: req_ready=1, out_valid=0, hit_way=0, trap_out=0, axi_arvalid=0, axi_rready=0, axi_rdata_q=0.
  - SRAM: cen=4'hF, wen=4'hF, bwen=all ones.
  - Arrays: all valid bits 0, round-robin counter 0, kill and fence-pending flags 0.
- Hit latency: accept in cycle 0, out_valid in cycle 1. Back-to-back hits sustain 1 per cycle.
- Miss latency: arvalid in cycle 1; FILL one cycle after the rvalid beat; out_valid one cycle after FILL.
- A hit result is held stable (hit_way, out_pc, trap_out) while out_valid && !out_ready.
- rst asserted mid-miss: the AXI transaction is abandoned and every state, output and flag returns to its reset value.

## Configuration
- YSYX_041461_ICACHE_EN defined: behaviour as above.
- Not defined:
  - Every fetch is treated as uncacheable and hit_way is always 0.
  - SRAMs are never enabled (cen=4'hF) and the tag/valid arrays are not instantiated.
  - fence_i completes in 1 cycle with no effect.

## Test plan
- Cold miss: pc=0x8000_0004, rdata=0x1111_2222_3333_4444, rresp=0 → fill of way 0 (sram_cen=4'b1110, bwen[63:0]=0), RESP with hit_way=0. Re-fetching 0x8000_0000 → hit_way=8'h01 one cycle after acceptance.
- Fill 9 distinct tags into index 0 → ways 0–7 fill in order. The 9th evicts round-robin way 0 (counter wrapped 7→0); sram_cen=4'b1110, bwen[63:0]=0.
- AXI error: rresp=2'b10 → trap_out=1, no SRAM write, a repeat fetch misses again.
- flush asserted in R with rvalid two cycles later → fill occurs, no out_valid, req_ready=1 afterwards.
- fence_i after a hit-populated cache → the next fetch of the same pc misses (arvalid=1).
- Back-pressure: out_ready=0 for 3 cycles on a hit → hit_way and out_pc stable, req_ready=0, then advance on out_ready=1.
